consumer_fsm: RTL and testbench

- Sink end of the dual-lane valid/flush/stall stream protocol driven by producer_fsm through the two pipelines.
- Generates periodic backpressure (stall) per lane and accepts beats.
- Checks each lane's sequence: strictly +STEP per accepted beat, with lane parity (lane 1 even, lane 2 odd).
- Reports accept counts, error counts, sticky error flags and the first offending data word.

---
 rtl/consumer_pkg.sv | 16 +
 rtl/consumer_fsm_seq_checker.sv | 94 +++++++++
 rtl/consumer_fsm.sv | 107 ++++++++++
 tb/tb_consumer_fsm.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/consumer_pkg.sv
// Shared definitions for the consumer_fsm sink: the per-lane checker state,
// the lane parity constants and the default sequence step.
package consumer_pkg;

   typedef enum logic {
      UNSYNC = 1'b0,
      TRACK  = 1'b1
   } lane_state_e;

   // Required value of data[0] on every accepted beat of each lane.
   localparam logic LANE1_PARITY = 1'b0;
   localparam logic LANE2_PARITY = 1'b1;

   localparam int unsigned DEFAULT_STEP = 2;

endpackage

// File: rtl/consumer_fsm_seq_checker.sv
// seq_checker: sequence checker for one stream lane.
// Accepts a beat when valid is high and neither stall nor flush is active.
// It checks that consecutive accepted beats differ by STEP and that
// data[0] matches PARITY, and it counts accepts and errors with saturating
// counters. The sticky flag and the first offending word are kept until reset.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   data, valid      lane beat from the pipeline
//   flush            drops sequence tracking (lane back to UNSYNC)
//   stall            current registered backpressure for this lane
//   accept_cnt       accepted beats (saturating)
//   err_cnt          sequence/parity errors (saturating)
//   err_sticky       set on first error
//   first_err_data   data word of the first error
module seq_checker
   import consumer_pkg::*;
#(
   parameter logic        PARITY = LANE1_PARITY,
   parameter int unsigned STEP   = DEFAULT_STEP,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      data,
   input  logic             valid,
   input  logic             flush,
   input  logic             stall,
   output logic [CNT_W-1:0] accept_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_sticky,
   output logic [31:0]      first_err_data
);

   lane_state_e      state_q, state_d;
   logic [31:0]      exp_q, exp_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [31:0]      first_q, first_d;
   logic             accept;
   logic             bad;

   assign accept = valid & ~stall & ~flush;

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      acc_d    = acc_q;
      err_d    = err_q;
      sticky_d = sticky_q;
      first_d  = first_q;
      bad      = 1'b0;
      if (flush) begin
         state_d = UNSYNC;
      end else if (accept) begin
         if (acc_q != '1) acc_d = acc_q + 1'b1;
         bad = (data[0] != PARITY) || ((state_q == TRACK) && (data != exp_q));
         // Resync on the received word so a single glitch is counted once.
         exp_d   = data + 32'(STEP);
         state_d = TRACK;
         if (bad) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!sticky_q) begin
               sticky_d = 1'b1;
               first_d  = data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= UNSYNC;
         exp_q    <= '0;
         acc_q    <= '0;
         err_q    <= '0;
         sticky_q <= 1'b0;
         first_q  <= '0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         first_q  <= first_d;
      end
   end

   assign accept_cnt     = acc_q;
   assign err_cnt        = err_q;
   assign err_sticky     = sticky_q;
   assign first_err_data = first_q;

endmodule

// File: rtl/consumer_fsm.sv
// consumer_fsm: sink end of the dual-lane valid/flush/stall stream.
// Generates periodic registered backpressure per lane (lane 2 offset by half a
// period) and checks each lane's sequence with a seq_checker instance.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   enable                       enables stall generation (checking always runs)
//   in_data_N/in_valid_N/in_flush_N   lane N stream inputs
//   out_stall_N                  registered backpressure to lane N
//   accept_cnt_N, err_cnt_N      per-lane saturating counters
//   err_sticky_N, first_err_data_N   per-lane first-error record
module consumer_fsm
   import consumer_pkg::*;
#(
   parameter int unsigned STALL_PERIOD = 8,
   parameter int unsigned STALL_LEN    = 2,
   parameter int unsigned STEP         = DEFAULT_STEP,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [31:0]      in_data_1,
   input  logic             in_valid_1,
   input  logic             in_flush_1,
   input  logic [31:0]      in_data_2,
   input  logic             in_valid_2,
   input  logic             in_flush_2,
   output logic             out_stall_1,
   output logic             out_stall_2,
   output logic [CNT_W-1:0] accept_cnt_1,
   output logic [CNT_W-1:0] accept_cnt_2,
   output logic [CNT_W-1:0] err_cnt_1,
   output logic [CNT_W-1:0] err_cnt_2,
   output logic             err_sticky_1,
   output logic             err_sticky_2,
   output logic [31:0]      first_err_data_1,
   output logic [31:0]      first_err_data_2
);

   localparam int unsigned PH_W = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

   logic [PH_W-1:0] phase_q, phase_d;
   logic            stall1_q, stall1_d;
   logic            stall2_q, stall2_d;

   always_comb begin
      phase_d  = phase_q;
      stall1_d = 1'b0;
      stall2_d = 1'b0;
      if (enable) begin
         phase_d  = (phase_q == PH_W'(STALL_PERIOD - 1)) ? '0 : phase_q + 1'b1;
         stall1_d = (32'(phase_q) < STALL_LEN);
         // Lane 2 sees the same pattern shifted by half a period.
         stall2_d = (((32'(phase_q) + STALL_PERIOD / 2) % STALL_PERIOD) < STALL_LEN);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q  <= '0;
         stall1_q <= 1'b0;
         stall2_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         stall1_q <= stall1_d;
         stall2_q <= stall2_d;
      end
   end

   assign out_stall_1 = stall1_q;
   assign out_stall_2 = stall2_q;

   seq_checker #(
      .PARITY (LANE1_PARITY),
      .STEP   (STEP),
      .CNT_W  (CNT_W)
   ) u_lane1 (
      .clk            (clk),
      .reset          (reset),
      .data           (in_data_1),
      .valid          (in_valid_1),
      .flush          (in_flush_1),
      .stall          (stall1_q),
      .accept_cnt     (accept_cnt_1),
      .err_cnt        (err_cnt_1),
      .err_sticky     (err_sticky_1),
      .first_err_data (first_err_data_1)
   );

   seq_checker #(
      .PARITY (LANE2_PARITY),
      .STEP   (STEP),
      .CNT_W  (CNT_W)
   ) u_lane2 (
      .clk            (clk),
      .reset          (reset),
      .data           (in_data_2),
      .valid          (in_valid_2),
      .flush          (in_flush_2),
      .stall          (stall2_q),
      .accept_cnt     (accept_cnt_2),
      .err_cnt        (err_cnt_2),
      .err_sticky     (err_sticky_2),
      .first_err_data (first_err_data_2)
   );

endmodule

// File: tb/tb_consumer_fsm.sv
module tb_consumer_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] in_data_1, in_data_2;
   logic        in_valid_1, in_valid_2;
   logic        in_flush_1, in_flush_2;
   logic        out_stall_1, out_stall_2;
   logic [15:0] accept_cnt_1, accept_cnt_2, err_cnt_1, err_cnt_2;
   logic        err_sticky_1, err_sticky_2;
   logic [31:0] first_err_data_1, first_err_data_2;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   consumer_fsm #(
      .STALL_PERIOD (8),
      .STALL_LEN    (2),
      .STEP         (2),
      .CNT_W        (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .in_data_1        (in_data_1),
      .in_valid_1       (in_valid_1),
      .in_flush_1       (in_flush_1),
      .in_data_2        (in_data_2),
      .in_valid_2       (in_valid_2),
      .in_flush_2       (in_flush_2),
      .out_stall_1      (out_stall_1),
      .out_stall_2      (out_stall_2),
      .accept_cnt_1     (accept_cnt_1),
      .accept_cnt_2     (accept_cnt_2),
      .err_cnt_1        (err_cnt_1),
      .err_cnt_2        (err_cnt_2),
      .err_sticky_1     (err_sticky_1),
      .err_sticky_2     (err_sticky_2),
      .first_err_data_1 (first_err_data_1),
      .first_err_data_2 (first_err_data_2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      in_valid_1 = 1'b0;
      in_valid_2 = 1'b0;
      in_flush_1 = 1'b0;
      in_flush_2 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Present a beat on lane 1, holding it while the consumer stalls.
   task automatic send1(input logic [31:0] d);
      logic stalled;
      int   n;
      in_data_1  = d;
      in_valid_1 = 1'b1;
      n = 0;
      do begin
         stalled = out_stall_1;
         tick();
         n++;
      end while (stalled && n < 20);
      if (stalled) check("send1_timeout", 32'(n), 32'd0);
      in_valid_1 = 1'b0;
   endtask

   task automatic send2(input logic [31:0] d);
      logic stalled;
      int   n;
      in_data_2  = d;
      in_valid_2 = 1'b1;
      n = 0;
      do begin
         stalled = out_stall_2;
         tick();
         n++;
      end while (stalled && n < 20);
      if (stalled) check("send2_timeout", 32'(n), 32'd0);
      in_valid_2 = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_s1, exp_s2;
      exp_s1 = 16'h0303;   // stall_1 high on cycles 1,2,9,10
      exp_s2 = 16'h3030;   // stall_2 high on cycles 5,6,13,14
      enable    = 1'b0;
      in_data_1 = '0;
      in_data_2 = '0;

      // Reset state
      do_reset();
      check("rst_stall1", 32'(out_stall_1), 32'd0);
      check("rst_stall2", 32'(out_stall_2), 32'd0);
      check("rst_acc1",   32'(accept_cnt_1), 32'd0);
      check("rst_err2",   32'(err_cnt_2), 32'd0);
      check("rst_first1", first_err_data_1, 32'd0);

      // Stall pattern
      enable = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         check($sformatf("stall1_c%0d", k + 1), 32'(out_stall_1), 32'(exp_s1[k]));
         check($sformatf("stall2_c%0d", k + 1), 32'(out_stall_2), 32'(exp_s2[k]));
      end
      enable = 1'b0;
      tick();
      check("dis_stall1", 32'(out_stall_1), 32'd0);
      check("dis_stall2", 32'(out_stall_2), 32'd0);
      enable = 1'b1;

      // Clean lane-1 sequence under stall
      do_reset();
      send1(32'd2); send1(32'd4); send1(32'd6); send1(32'd8);
      check("clean_acc1",    32'(accept_cnt_1), 32'd4);
      check("clean_err1",    32'(err_cnt_1), 32'd0);
      check("clean_sticky1", 32'(err_sticky_1), 32'd0);

      // Single sequence break then resync
      do_reset();
      send1(32'd2); send1(32'd4); send1(32'd10); send1(32'd12);
      check("jump_err1",   32'(err_cnt_1), 32'd1);
      check("jump_first1", first_err_data_1, 32'd10);
      check("jump_acc1",   32'(accept_cnt_1), 32'd4);
      check("jump_stk1",   32'(err_sticky_1), 32'd1);

      // Lane-2 parity error while UNSYNC; second error keeps the first word
      do_reset();
      send2(32'h4);
      check("par_stk2",   32'(err_sticky_2), 32'd1);
      check("par_first2", first_err_data_2, 32'h4);
      check("par_err2",   32'(err_cnt_2), 32'd1);
      check("par_acc2",   32'(accept_cnt_2), 32'd1);
      check("par_acc1",   32'(accept_cnt_1), 32'd0);
      check("par_stk1",   32'(err_sticky_1), 32'd0);
      send2(32'h7);   // expected 6 -> error, odd parity fine
      check("par2_err2",   32'(err_cnt_2), 32'd2);
      check("par2_first2", first_err_data_2, 32'h4);

      // Flush beats valid in the same cycle
      do_reset();
      send1(32'h100);
      in_data_1  = 32'h300;
      in_valid_1 = 1'b1;
      in_flush_1 = 1'b1;
      tick();
      in_valid_1 = 1'b0;
      in_flush_1 = 1'b0;
      check("flush_acc1a", 32'(accept_cnt_1), 32'd1);
      send1(32'h302);
      check("flush_acc1", 32'(accept_cnt_1), 32'd2);
      check("flush_err1", 32'(err_cnt_1), 32'd0);

      // 32-bit wrap of the expected value
      do_reset();
      send1(32'hFFFF_FFFE); send1(32'h0000_0000);
      check("wrap_err1", 32'(err_cnt_1), 32'd0);
      check("wrap_acc1", 32'(accept_cnt_1), 32'd2);
      send1(32'h5);   // expected 2 and odd -> one error
      check("bad_first1", first_err_data_1, 32'h5);
      send2(32'h9);

      // Reset asserted mid-stream with valid held
      in_data_1  = 32'h8;
      in_valid_1 = 1'b1;
      reset      = 1'b1;
      tick();
      check("mid_acc1",   32'(accept_cnt_1), 32'd0);
      check("mid_acc2",   32'(accept_cnt_2), 32'd0);
      check("mid_err1",   32'(err_cnt_1), 32'd0);
      check("mid_stk1",   32'(err_sticky_1), 32'd0);
      check("mid_first1", first_err_data_1, 32'd0);
      check("mid_stall1", 32'(out_stall_1), 32'd0);
      check("mid_stall2", 32'(out_stall_2), 32'd0);
      reset      = 1'b0;
      in_valid_1 = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
